// File: rtl/regfile_wb_queue.sv
// Writeback queue driving the regfile write port, with optional read-port forwarding.
// Define WBQ_BYPASS_EN to forward pending results onto RdA/RdB; otherwise RdA/RdB pass DoA/DoB.
module regfile_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [AW-1:0]                in_addr,
    input  logic [DW-1:0]                in_data,
    output logic [AW-1:0]                AddrC,
    output logic [DW-1:0]                DinC,
    output logic                         wrback,
    input  logic [AW-1:0]                AddrA,
    input  logic [AW-1:0]                AddrB,
    input  logic [DW-1:0]                DoA,
    input  logic [DW-1:0]                DoB,
    output logic [DW-1:0]                RdA,
    output logic [DW-1:0]                RdB,
    output logic                         hitA,
    output logic                         hitB,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         idle
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] addrMem [DEPTH];
    logic [DW-1:0] dataMem [DEPTH];
    logic [PW-1:0] wrPtrQ, rdPtrQ;
    logic [CW-1:0] countQ;
    logic          doPush, doPop;

    // Ready looks only at the registered count, so a full queue refuses even on a pop edge.
    assign in_ready = (countQ != CW'(DEPTH));
    // Writes to r0 complete the handshake but are never queued.
    assign doPush   = in_valid && in_ready && (in_addr != '0);
    assign doPop    = (countQ != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
            wrback <= 1'b0;
            AddrC  <= '0;
            DinC   <= '0;
        end else begin
            if (doPush) begin
                wrPtrQ <= wrPtrQ + PW'(1);
            end
            if (doPop) begin
                rdPtrQ <= rdPtrQ + PW'(1);
                AddrC  <= addrMem[rdPtrQ];
                DinC   <= dataMem[rdPtrQ];
            end
            wrback <= doPop;
            countQ <= countQ + CW'(doPush) - CW'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            addrMem[wrPtrQ] <= in_addr;
            dataMem[wrPtrQ] <= in_data;
        end
    end

    assign count = countQ;
    assign idle  = (countQ == '0) && !wrback;

`ifdef WBQ_BYPASS_EN
    // Oldest candidate first so younger matches overwrite: output stage, then FIFO head..tail.
    always_comb begin
        logic [PW-1:0] idx;
        idx  = '0;
        RdA  = DoA;
        RdB  = DoB;
        hitA = 1'b0;
        hitB = 1'b0;
        if (wrback && (AddrA != '0) && (AddrC == AddrA)) begin
            RdA  = DinC;
            hitA = 1'b1;
        end
        if (wrback && (AddrB != '0) && (AddrC == AddrB)) begin
            RdB  = DinC;
            hitB = 1'b1;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rdPtrQ + PW'(i);
            if (CW'(i) < countQ) begin
                if ((AddrA != '0) && (addrMem[idx] == AddrA)) begin
                    RdA  = dataMem[idx];
                    hitA = 1'b1;
                end
                if ((AddrB != '0) && (addrMem[idx] == AddrB)) begin
                    RdB  = dataMem[idx];
                    hitB = 1'b1;
                end
            end
        end
    end
`else
    logic unusedAddr;
    assign unusedAddr = ^{AddrA, AddrB};
    assign RdA  = DoA;
    assign RdB  = DoB;
    assign hitA = 1'b0;
    assign hitB = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: constant vector table, directed forwarding
// sequence, and randomized traffic against a queue-based reference model.
module tb_regfile_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, wrback, hitA, hitB, idle;
    logic [AW-1:0] in_addr, AddrC, AddrA, AddrB;
    logic [DW-1:0] in_data, DinC, DoA, DoB, RdA, RdB;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .AddrC(AddrC), .DinC(DinC), .wrback(wrback),
        .AddrA(AddrA), .AddrB(AddrB), .DoA(DoA), .DoB(DoB), .RdA(RdA), .RdB(RdB),
        .hitA(hitA), .hitB(hitB), .count(count), .idle(idle)
    );

    always #5 clk = ~clk;

    // Reference model: pending results in program order, one output stage, external regfile.
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    ent_t          q[$];
    logic          mWr;
    logic [AW-1:0] mAddrC;
    logic [DW-1:0] mDinC;
    logic [DW-1:0] rf [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelEdge();
        bit acc;
        if (mWr) rf[mAddrC] = mDinC;
        if (!rst_n) begin
            q.delete();
            mWr    = 1'b0;
            mAddrC = '0;
            mDinC  = '0;
        end else begin
            acc = in_valid && (q.size() < DEPTH);
            if (q.size() > 0) begin
                mAddrC = q[0].a;
                mDinC  = q[0].d;
                mWr    = 1'b1;
                void'(q.pop_front());
            end else begin
                mWr = 1'b0;
            end
            if (acc && in_addr != '0) q.push_back('{a: in_addr, d: in_data});
        end
    endtask

    task automatic fwd(input logic [AW-1:0] a, input logic [DW-1:0] dout,
                       output logic [DW-1:0] rd, output logic hit);
        rd  = dout;
        hit = 1'b0;
`ifdef WBQ_BYPASS_EN
        if (a != '0) begin
            if (mWr && mAddrC == a) begin
                rd  = mDinC;
                hit = 1'b1;
            end
            foreach (q[i]) begin
                if (q[i].a == a) begin
                    rd  = q[i].d;
                    hit = 1'b1;
                end
            end
        end
`endif
    endtask

    task automatic checkModel();
        logic [DW-1:0] eRd;
        logic          eHit;
        chk("in_ready", in_ready, (q.size() != DEPTH));
        chk("count", count, q.size());
        chk("wrback", wrback, mWr);
        chk("AddrC", AddrC, mAddrC);
        chk("DinC", DinC, mDinC);
        chk("idle", idle, (q.size() == 0) && !mWr);
        fwd(AddrA, DoA, eRd, eHit);
        chk("RdA", RdA, eRd);
        chk("hitA", hitA, eHit);
        fwd(AddrB, DoB, eRd, eHit);
        chk("RdB", RdB, eRd);
        chk("hitB", hitB, eHit);
    endtask

    task automatic cycle(input logic r, input logic v, input logic [AW-1:0] ad,
                         input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [AW-1:0] b);
        rst_n    = r;
        in_valid = v;
        in_addr  = ad;
        in_data  = d;
        AddrA    = a;
        AddrB    = b;
        DoA      = rf[a];
        DoB      = rf[b];
        @(posedge clk);
        modelEdge();
        #1;
        DoA = rf[AddrA];
        DoB = rf[AddrB];
        #1;
        checkModel();
    endtask

    typedef struct {
        logic          r, v;
        logic [AW-1:0] ad;
        logic [DW-1:0] d;
        logic          rdy, wr;
        logic [AW-1:0] ac;
        logic [DW-1:0] dc;
        logic [CW-1:0] cnt;
        logic          idl;
    } vec_t;

    function automatic vec_t mk(logic r, logic v, logic [AW-1:0] ad, logic [DW-1:0] d,
                                logic wr, logic [AW-1:0] ac, logic [DW-1:0] dc,
                                logic [CW-1:0] cnt, logic idl);
        return '{r: r, v: v, ad: ad, d: d, rdy: 1'b1, wr: wr, ac: ac, dc: dc, cnt: cnt, idl: idl};
    endfunction

    localparam logic [DW-1:0] NEG2540 = 32'hFFFF_F614;

    vec_t tbl[16];

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        mWr = 1'b0; mAddrC = '0; mDinC = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        AddrA = '0; AddrB = '0; DoA = '0; DoB = '0;

        // Columns after the data: expected wrback, AddrC, DinC, count, idle after the edge.
        tbl[0]  = mk(0, 1, 3,  5,       0, 0, 0,       0, 1);  // reset with valid high
        tbl[1]  = mk(1, 1, 1,  NEG2540, 0, 0, 0,       1, 0);
        tbl[2]  = mk(1, 0, 0,  0,       1, 1, NEG2540, 0, 0);
        tbl[3]  = mk(1, 0, 0,  0,       0, 1, NEG2540, 0, 1);
        tbl[4]  = mk(1, 1, 4,  40,      0, 1, NEG2540, 1, 0);  // DEPTH+1 back-to-back
        tbl[5]  = mk(1, 1, 5,  50,      1, 4, 40,      1, 0);
        tbl[6]  = mk(1, 1, 6,  60,      1, 5, 50,      1, 0);
        tbl[7]  = mk(1, 1, 7,  70,      1, 6, 60,      1, 0);
        tbl[8]  = mk(1, 1, 8,  80,      1, 7, 70,      1, 0);
        tbl[9]  = mk(1, 0, 0,  0,       1, 8, 80,      0, 0);
        tbl[10] = mk(1, 0, 0,  0,       0, 8, 80,      0, 1);
        tbl[11] = mk(1, 1, 0,  123,     0, 8, 80,      0, 1);  // r0 write dropped
        tbl[12] = mk(1, 0, 0,  0,       0, 8, 80,      0, 1);
        tbl[13] = mk(1, 1, 9,  900,     0, 8, 80,      1, 0);
        tbl[14] = mk(0, 1, 10, 1000,    0, 0, 0,       0, 1);  // reset discards pending
        tbl[15] = mk(1, 0, 0,  0,       0, 0, 0,       0, 1);

        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].ad, tbl[i].d, 0, 0);
            chk($sformatf("vec%0d.ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("vec%0d.wrback", i), wrback, tbl[i].wr);
            chk($sformatf("vec%0d.AddrC", i), AddrC, tbl[i].ac);
            chk($sformatf("vec%0d.DinC", i), DinC, tbl[i].dc);
            chk($sformatf("vec%0d.count", i), count, tbl[i].cnt);
            chk($sformatf("vec%0d.idle", i), idle, tbl[i].idl);
            chk($sformatf("vec%0d.RdA_r0", i), {hitA, RdA}, {1'b0, DoA});
        end

        // Forwarding: youngest pending entry beats the output stage.
        cycle(1, 1, 1, NEG2540, 1, 2);
        cycle(1, 1, 2, 2550, 1, 2);
        cycle(1, 1, 1, 7, 1, 2);
`ifdef WBQ_BYPASS_EN
        chk("fw3.RdA", RdA, 7);
        chk("fw3.hitA", hitA, 1'b1);
        chk("fw3.RdB", RdB, 2550);
        chk("fw3.hitB", hitB, 1'b1);
`else
        chk("fw3.RdA", RdA, NEG2540);
        chk("fw3.hitA", hitA, 1'b0);
`endif
        cycle(1, 0, 0, 0, 1, 2);
        chk("fw4.RdB", RdB, 2550);
        chk("fw4.hitB", hitB, 1'b0);
`ifdef WBQ_BYPASS_EN
        chk("fw4.RdA", RdA, 7);
        chk("fw4.hitA", hitA, 1'b1);
`endif
        cycle(1, 0, 0, 0, 1, 2);
        chk("fw5.RdA", RdA, 7);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) != 0), $urandom_range(0, 1), AW'($urandom_range(0, 7)),
                  $urandom, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
